// File: rtl/hmi_key_if.sv
// hmi_key_if: panel-side bundle for the HMI key conditioner.
// The slave modport is the conditioner itself: it consumes the raw
// active-low keys and drives the press events, setpoint and run flag.
// The master modport is whoever owns the panel keys and listens to the
// results (the front-panel wiring, or a testbench).
interface hmi_key_if;

  // Raw panel keys, active low: [0] up, [1] down, [2] run/stop
  logic [2:0] key;

  // One-cycle press event per key
  logic [2:0] key_evt;

  // Saturating frequency setpoint
  logic [9:0] freq;

  // Run/stop flag
  logic       run;

  modport master (
    output key,
    input  key_evt,
    input  freq,
    input  run
  );

  modport slave (
    input  key,
    output key_evt,
    output freq,
    output run
  );

endinterface

// File: rtl/hmi_key.sv
// hmi_key: front-panel key conditioner and frequency setpoint generator.
//
// Each of the three active-low panel keys is brought into the clk_sys
// domain through a two-flop chain, debounced with its own counter, and
// turned into a single-cycle press event on the debounced 1->0 edge.
// Releases never generate events.
//
// The up and down keys step a saturating 10-bit setpoint; the run/stop
// key toggles the run flag. Simultaneous up and down steps cancel.
//
// Build option HMI_KEY_REPEAT_EN:
//   defined   - each of the up/down keys gets an IDLE/HOLD/REPEAT FSM, so
//               holding a key past HOLD_CNT cycles produces further steps
//               every REP_CNT cycles until the key is released.
//   undefined - no FSM and no hold/repeat counters; a press is exactly
//               one step no matter how long the key is held.
module hmi_key #(
  parameter logic [19:0] DEB_CNT   = 20'd1_000_000,
  parameter logic [24:0] HOLD_CNT  = 25'd25_000_000,
  parameter logic [24:0] REP_CNT   = 25'd5_000_000,
  parameter logic [9:0]  FREQ_MIN  = 10'd0,
  parameter logic [9:0]  FREQ_MAX  = 10'd500,
  parameter logic [9:0]  FREQ_INIT = 10'd50,
  parameter logic [9:0]  STEP      = 10'd1
) (
  input  logic       clk_sys,
  input  logic       rst,
  hmi_key_if.slave   bus
);

  // Synchroniser chain, both stages idle at "released"
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;

  // Debounced key levels and the previous-cycle copy used for edge detect
  logic [2:0]  r_deb;
  logic [2:0]  r_deb_d;

  // Per-key debounce counters
  logic [19:0] r_deb_cnt [3];

  // Registered press events
  logic [2:0]  r_evt;

  // Setpoint and run flag
  logic [9:0]  r_freq;
  logic        r_run;

  // Step requests for the setpoint: [0] up, [1] down
  logic [1:0]  w_step;

  // Saturation arithmetic for the two step directions
  logic [10:0] w_up_sum;
  logic [10:0] w_dn_floor;
  logic [9:0]  w_up_next;
  logic [9:0]  w_dn_next;

  // Two-flop synchroniser for the raw asynchronous keys
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= bus.key;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: adopt the synchronised level only after it has disagreed
  // with the debounced level for DEB_CNT consecutive cycles
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_deb <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] >= DEB_CNT - 20'd1) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Press event: one registered pulse on each debounced falling edge
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_deb_d <= 3'b111;
      r_evt   <= 3'b000;
    end else begin
      r_deb_d <= r_deb;
      r_evt   <= r_deb_d & ~r_deb;
    end
  end

`ifdef HMI_KEY_REPEAT_EN

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Auto-repeat state and hold/repeat interval counter per up/down key
  rep_state_t  r_state   [2];
  logic [24:0] r_rep_cnt [2];

  // Step decode: the press itself, hold expiry, and every repeat interval,
  // suppressed as soon as the debounced level shows the key released
  always_comb begin
    w_step = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (r_state[i])
        ST_IDLE:   w_step[i] = r_evt[i];
        ST_HOLD:   w_step[i] = ~r_deb[i] && (r_rep_cnt[i] >= HOLD_CNT - 25'd1);
        ST_REPEAT: w_step[i] = ~r_deb[i] && (r_rep_cnt[i] >= REP_CNT - 25'd1);
        default:   w_step[i] = 1'b0;
      endcase
    end
  end

  // Hold/repeat FSM: press enters HOLD, hold expiry enters REPEAT,
  // debounced release always returns to IDLE
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]   <= ST_IDLE;
        r_rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            r_rep_cnt[i] <= '0;
            if (r_evt[i]) begin
              r_state[i] <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (r_deb[i]) begin
              r_state[i]   <= ST_IDLE;
              r_rep_cnt[i] <= '0;
            end else if (w_step[i]) begin
              r_state[i]   <= ST_REPEAT;
              r_rep_cnt[i] <= '0;
            end else begin
              r_rep_cnt[i] <= r_rep_cnt[i] + 25'd1;
            end
          end
          ST_REPEAT: begin
            if (r_deb[i]) begin
              r_state[i]   <= ST_IDLE;
              r_rep_cnt[i] <= '0;
            end else if (w_step[i]) begin
              r_rep_cnt[i] <= '0;
            end else begin
              r_rep_cnt[i] <= r_rep_cnt[i] + 25'd1;
            end
          end
          default: begin
            r_state[i]   <= ST_IDLE;
            r_rep_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

`else

  // Without auto-repeat every press is exactly one step
  assign w_step = r_evt[1:0];

`endif

  // The up comparison is made one bit wider so a sum past 1023 still
  // saturates instead of wrapping back below FREQ_MAX
  assign w_up_sum   = {1'b0, r_freq} + {1'b0, STEP};
  assign w_up_next  = (w_up_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_up_sum[9:0];
  assign w_dn_floor = {1'b0, FREQ_MIN} + {1'b0, STEP};
  assign w_dn_next  = ({1'b0, r_freq} < w_dn_floor) ? FREQ_MIN : (r_freq - STEP);

  // Setpoint register: a lone up or down step moves it, both together cancel
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_freq <= FREQ_INIT;
    end else begin
      case (w_step)
        2'b01:   r_freq <= w_up_next;
        2'b10:   r_freq <= w_dn_next;
        default: r_freq <= r_freq;
      endcase
    end
  end

  // Run flag toggles on every run/stop press
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_run <= 1'b0;
    end else if (r_evt[2]) begin
      r_run <= ~r_run;
    end
  end

  assign bus.key_evt = r_evt;
  assign bus.freq    = r_freq;
  assign bus.run     = r_run;

endmodule
